// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the serial shift-and-add-3 binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DIGIT_W = 4;

    // A digit at 5 or above would reach 10+ after the next doubling; adding 3 first
    // makes the doubled value carry into the next digit instead.
    localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational conditional add-3 for one BCD work digit, applied before each left shift.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Iterative binary-to-BCD converter: one bit per cycle, BIN_WIDTH+1 cycles start to done.
// Optional leading-zero blanking mask on digit_en is enabled by defining BIN_TO_BCD_LZ_BLANK_EN.
module bin_to_bcd_serial
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   overflow,
    output logic [DIGITS-1:0]      digit_en,
    output logic [1:0]             dbg_state_o
);

    localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
    localparam int WORK_W = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Handshake: start is a request sampled on a rising edge only while the FSM is idle;
    // busy is the not-ready indication, done is a one-cycle valid for bcd/overflow/digit_en.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] sr_q, sr_d;
    logic [WORK_W-1:0]  work_q, work_d, work_adj;
    logic               ovf_work_q, ovf_work_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WORK_W-1:0]  bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (work_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d       = bin;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_d     = 1'b1;
                // Bit leaving the top digit would belong to a digit we do not have.
                work_d     = {work_adj[WORK_W-2:0], sr_q[BIN_WIDTH-1]};
                ovf_work_d = ovf_work_q | work_adj[WORK_W-1];
                sr_d       = sr_q << 1;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                bcd_d   = work_q;
                ovf_d   = ovf_work_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef BIN_TO_BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] den_q, den_next;
    logic              seen;

    // A digit is significant if it or any more-significant digit is nonzero.
    always_comb begin
        den_next = '0;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (|work_q[i*DIGIT_W +: DIGIT_W]);
            den_next[i] = seen;
        end
        den_next[0] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            den_q <= '0;
        end else if (state_q == ST_DONE) begin
            den_q <= den_next;
        end
    end

    assign digit_en = den_q;
`else
    assign digit_en = '1;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign bcd         = bcd_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed + random bench for bin_to_bcd_serial (5-digit default and a 4-digit overflow instance).
module tb_bin_to_bcd_serial;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, sel;
    logic [15:0] bin;

    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  den5;
    logic [1:0]  dbg5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  den4;
    logic [1:0]  dbg4;
    logic        start5, start4;

    assign start5 = start & ~sel;
    assign start4 = start & sel;

    bin_to_bcd_serial u_dut5 (
        .clock(clock), .reset(reset), .start(start5), .bin(bin),
        .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5),
        .digit_en(den5), .dbg_state_o(dbg5)
    );

    bin_to_bcd_serial #(.BIN_WIDTH(16), .DIGITS(4)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4),
        .digit_en(den4), .dbg_state_o(dbg4)
    );

    logic        cur_busy, cur_done;
    logic [25:0] cur_res;
    assign cur_busy = sel ? busy4 : busy5;
    assign cur_done = sel ? done4 : done5;
    assign cur_res  = sel ? {ovf4, 1'b0, den4, 4'h0, bcd4} : {ovf5, den5, bcd5};

`ifdef BIN_TO_BCD_LZ_BLANK_EN
    localparam logic [4:0] RST_DEN5 = 5'b00000;
    localparam logic [3:0] RST_DEN4 = 4'b0000;
`else
    localparam logic [4:0] RST_DEN5 = 5'b11111;
    localparam logic [3:0] RST_DEN4 = 4'b1111;
`endif

    logic [25:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference: decimal digits by repeated division; {overflow, mask[4:0], bcd[19:0]}.
    function automatic logic [25:0] model(input logic [15:0] b, input int nd);
        logic [19:0] d;
        logic [4:0]  m;
        int          v;
        logic        ov;
        logic        seen;
        v = int'(b);
        d = '0;
        m = '0;
        for (int i = 0; i < nd; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        ov = (v != 0);
`ifdef BIN_TO_BCD_LZ_BLANK_EN
        seen = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (i < nd) begin
                if (d[4*i +: 4] != 4'h0) seen = 1'b1;
                m[i] = seen;
            end
        end
        m[0] = 1'b1;
`else
        seen = 1'b0;
        for (int i = 0; i < nd; i++) m[i] = 1'b1;
`endif
        return {ov, m, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [15:0] b);
        start = 1'b1;
        bin   = b;
        exp_q.push_back(model(b, sel ? 4 : 5));
        @(negedge clock);
        start = 1'b0;
        bin   = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input int inj_at, input logic [15:0] inj_bin, input bit chk_timing);
        int          lat = 0;
        int          busy_cnt = 0;
        logic [25:0] e;
        while (cur_done !== 1'b1 && lat < 60) begin
            if (cur_busy === 1'b1) busy_cnt++;
            if (lat == inj_at) begin
                start = 1'b1;
                bin   = inj_bin;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", {31'b0, cur_done}, 32'd1);
        chk("queue_nonempty", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("result", {6'b0, cur_res}, {6'b0, e});
        if (chk_timing) begin
            chk("latency", lat, 17);
            chk("busy_cycles", busy_cnt, 16);
            chk("busy_at_done", {31'b0, cur_busy}, 32'd0);
            @(negedge clock);
            chk("done_one_cycle", {31'b0, cur_done}, 32'd0);
            chk("hold", {6'b0, cur_res}, {6'b0, e});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        sel   = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy5", {31'b0, busy5}, 32'd0);
        chk("rst_done5", {31'b0, done5}, 32'd0);
        chk("rst_res5", {6'b0, ovf5, den5, bcd5}, {6'b0, 1'b0, RST_DEN5, 20'h0});
        chk("rst_res4", {11'b0, ovf4, den4, bcd4}, {11'b0, 1'b0, RST_DEN4, 16'h0});
        reset = 1'b0;
        @(negedge clock);

        start_conv(16'd0);
        wait_done(-1, 16'd0, 1'b1);
        start_conv(16'hFFFF);
        wait_done(-1, 16'd0, 1'b1);
        chk("ffff_bcd", {12'b0, bcd5}, 32'h65535);
        start_conv(16'd1234);
        wait_done(-1, 16'd0, 1'b1);
        chk("1234_bcd", {12'b0, bcd5}, 32'h01234);

        // Start mid-conversion with a different value must be dropped.
        start_conv(16'd4321);
        wait_done(3, 16'd777, 1'b1);
        dones = 0;
        repeat (20) begin
            @(negedge clock);
            if (done5 === 1'b1) dones++;
        end
        chk("no_queued_start", dones, 0);

        // Back-to-back: start in the done cycle.
        start_conv(16'd50000);
        wait_done(-1, 16'd0, 1'b0);
        start_conv(16'd42);
        wait_done(-1, 16'd0, 1'b1);

        // Reset during cycle 8 aborts and clears the result.
        start_conv(16'd9876);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", {31'b0, busy5}, 32'd0);
        chk("abort_done", {31'b0, done5}, 32'd0);
        chk("abort_res", {6'b0, ovf5, den5, bcd5}, {6'b0, 1'b0, RST_DEN5, 20'h0});
        reset = 1'b0;
        exp_q.delete();
        dones = 0;
        repeat (20) begin
            @(negedge clock);
            if (done5 === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        start_conv(16'd305);
        wait_done(-1, 16'd0, 1'b1);

        // Four-digit instance: overflow boundary.
        sel = 1'b1;
        @(negedge clock);
        start_conv(16'd10000);
        wait_done(-1, 16'd0, 1'b1);
        chk("ovf_10000", {31'b0, ovf4}, 32'd1);
        start_conv(16'd9999);
        wait_done(-1, 16'd0, 1'b1);
        chk("ovf_9999", {31'b0, ovf4}, 32'd0);
        repeat (4) begin
            start_conv(16'($urandom_range(0, 65535)));
            wait_done(-1, 16'd0, 1'b0);
        end

        sel = 1'b0;
        @(negedge clock);
        repeat (6) begin
            start_conv(16'($urandom_range(0, 65535)));
            wait_done(-1, 16'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
